// File: rtl/sram_share_pkg.sv
// Shared types for the SRAM sharing arbiter: requester index width and the
// tag that follows each granted access through the command and return stages.
package sram_share_pkg;

  localparam int MAXREQ = 4;
  localparam int IDXW   = $clog2(MAXREQ);

  typedef logic [IDXW-1:0] idx_t;

  typedef struct packed {
    logic valid;
    logic read;
    idx_t idx;
    logic fault;
  } tag_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin one-hot picker: the search starts one past ptr_i and wraps,
// so the most recently granted requester has the lowest priority.
module rr_pick
  import sram_share_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] req_i,
  input  idx_t         ptr_i,
  output logic [N-1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    // Walk from the farthest candidate to the nearest so the nearest wins.
    for (int k = N; k >= 1; k--) begin
      if (req_i[(int'(ptr_i) + k) % N]) begin
        gnt_o = '0;
        gnt_o[(int'(ptr_i) + k) % N] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_share_arbiter.sv
// Shares one single-port SRAM between NREQ requesters with private address
// windows; escalated > urgent > normal priority, one grant per cycle.
module sram_share_arbiter
  import sram_share_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int DWID    = 64,
  parameter int AWID    = 10,
  parameter int MAXWAIT = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     softreset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          urgent,
  input  logic [NREQ-1:0]          req_wen,
  input  logic [NREQ*AWID-1:0]     req_addr,
  input  logic [NREQ*DWID-1:0]     req_wdata,
  input  logic [NREQ*AWID-1:0]     base,
  input  logic [NREQ*(AWID+1)-1:0] size,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rvalid,
  output logic [DWID-1:0]          rdata,
  output logic                     ram_cen,
  output logic                     ram_wen,
  output logic [AWID-1:0]          ram_addr,
  output logic [DWID-1:0]          ram_wdata,
  input  logic [DWID-1:0]          ram_rdata,
  output logic [NREQ-1:0]          err_range,
  output logic                     busy
);

  localparam int WW = $clog2(MAXWAIT + 1);
  typedef logic [WW-1:0] wait_t;

  logic [NREQ-1:0] esc, urg_req, gnt_urg, gnt_all, err_q, err_d;
  idx_t            ptr_q, ptr_d, gidx;
  logic            any_gnt, sel_fault;
  logic [AWID-1:0] sel_addr;
  tag_t            tag1_q, tag1_d, tag2_q, tag2_d;
  logic            ram_cen_q, ram_cen_d, ram_wen_q, ram_wen_d, rd_ret;
  logic [AWID-1:0] ram_addr_q, ram_addr_d;
  logic [DWID-1:0] ram_wdata_q, ram_wdata_d, rdata_q, rdata_d;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    wait_t wait_q, wait_d;

    assign esc[gi]    = req[gi] && (wait_q == wait_t'(MAXWAIT));
    assign rvalid[gi] = rd_ret && (tag2_q.idx == idx_t'(gi));

    always_comb begin
      wait_d = wait_q;
      if (softreset || !req[gi] || gnt[gi]) wait_d = '0;
      else if (wait_q != wait_t'(MAXWAIT))   wait_d = wait_q + wait_t'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wait_q <= '0;
      else        wait_q <= wait_d;
    end
  end

  assign urg_req = req & urgent;

  rr_pick #(.N(NREQ)) u_pick_urg (.req_i(urg_req), .ptr_i(ptr_q), .gnt_o(gnt_urg));
  rr_pick #(.N(NREQ)) u_pick_all (.req_i(req),     .ptr_i(ptr_q), .gnt_o(gnt_all));

  always_comb begin
    gnt = '0;
    if (rst_n && !softreset) begin
      if (|esc)          gnt = esc & (-esc);  // lowest escalated index
      else if (|urg_req) gnt = gnt_urg;
      else               gnt = gnt_all;
    end
  end

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NREQ; i++) if (gnt[i]) gidx = idx_t'(i);
  end

  assign any_gnt   = |gnt;
  assign sel_addr  = req_addr[int'(gidx)*AWID +: AWID];
  assign sel_fault = {1'b0, sel_addr} >= size[int'(gidx)*(AWID+1) +: AWID+1];

  always_comb begin
    ptr_d       = any_gnt ? gidx : ptr_q;
    ram_cen_d   = 1'b1;
    ram_wen_d   = 1'b1;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if (any_gnt && !sel_fault) begin
      ram_cen_d   = 1'b0;
      ram_wen_d   = !req_wen[gidx];
      ram_addr_d  = base[int'(gidx)*AWID +: AWID] + sel_addr;
      ram_wdata_d = req_wdata[int'(gidx)*DWID +: DWID];
    end
    tag1_d.valid = any_gnt;
    tag1_d.read  = !req_wen[gidx];
    tag1_d.idx   = gidx;
    tag1_d.fault = sel_fault;
    tag2_d       = tag1_q;
    rdata_d      = rdata;
    if (softreset) begin
      ptr_d       = idx_t'(NREQ - 1);
      ram_addr_d  = '0;
      ram_wdata_d = '0;
      tag1_d      = '0;
      tag2_d      = '0;
      rdata_d     = '0;
    end
  end

  // Faulted reads return zero; otherwise the SRAM output passes through on the
  // return cycle and the register keeps it visible afterwards.
  assign rd_ret = tag2_q.valid && tag2_q.read;
  assign rdata  = rd_ret ? (tag2_q.fault ? '0 : ram_rdata) : rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= idx_t'(NREQ - 1);
      ram_cen_q   <= 1'b1;
      ram_wen_q   <= 1'b1;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      tag1_q      <= '0;
      tag2_q      <= '0;
      rdata_q     <= '0;
    end else begin
      ptr_q       <= ptr_d;
      ram_cen_q   <= ram_cen_d;
      ram_wen_q   <= ram_wen_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag2_d;
      rdata_q     <= rdata_d;
    end
  end

  // Fault flags survive softreset so firmware can still read them afterwards.
  assign err_d = err_q | ((any_gnt && sel_fault) ? gnt : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= '0;
    else        err_q <= err_d;
  end

  assign err_range = err_q;
  assign ram_cen   = ram_cen_q;
  assign ram_wen   = ram_wen_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = tag1_q.valid || rd_ret;

endmodule
